mac_mdc_tcdm_responder: RTL



---
 rtl/mac_mdc_tcdm_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mac_mdc_tcdm_responder.sv
// Banked, word-interleaved TCDM slave: per-bank round-robin grant in the request cycle, response one cycle later.
// Responses have no back-pressure; stalled or conflicting requests stay pending until granted.
module mac_mdc_tcdm_responder #(
  parameter int MP         = 4,
  parameter int N_BANKS    = 4,
  parameter int BANK_WORDS = 256,
  parameter int CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                test_mode_i,
  input  logic                clear_i,
  input  logic [MP-1:0]       stall_i,
  input  logic [MP-1:0]       tcdm_req_i,
  output logic [MP-1:0]       tcdm_gnt_o,
  input  logic [MP*32-1:0]    tcdm_add_i,
  input  logic [MP-1:0]       tcdm_wen_i,
  input  logic [MP*4-1:0]     tcdm_be_i,
  input  logic [MP*32-1:0]    tcdm_data_i,
  output logic [MP*32-1:0]    tcdm_r_data_o,
  output logic [MP-1:0]       tcdm_r_valid_o,
  output logic [CNT_W-1:0]    n_gnt_o,
  output logic [CNT_W-1:0]    n_conflict_o
);

  localparam int BANK_SH = $clog2(N_BANKS);
  localparam int BK_W    = (N_BANKS > 1) ? BANK_SH : 1;
  localparam int ROW_W   = $clog2(BANK_WORDS);
  localparam int PTR_W   = (MP > 1) ? $clog2(MP) : 1;
  localparam int INC_W   = $clog2(MP + 1);
  localparam int SUM_W   = CNT_W + 1;

  function automatic int rr_port(input logic [PTR_W-1:0] ptr, input int ofs);
    return (int'(ptr) + ofs) % MP;
  endfunction

  logic [31:0]       mem_q [N_BANKS][BANK_WORDS];

  logic [BK_W-1:0]   port_bank [MP];
  logic [ROW_W-1:0]  port_row  [MP];

  logic [PTR_W-1:0]  rr_ptr_q [N_BANKS];
  logic [PTR_W-1:0]  rr_ptr_d [N_BANKS];
  logic [N_BANKS-1:0] bank_hit;
  logic [PTR_W-1:0]  bank_port [N_BANKS];
  logic [MP-1:0]     win;
  logic [MP-1:0]     gnt;

  logic [N_BANKS-1:0] bank_we;
  logic [ROW_W-1:0]  bank_row   [N_BANKS];
  logic [31:0]       bank_wdata [N_BANKS];
  logic [3:0]        bank_be    [N_BANKS];

  logic [MP-1:0]     r_valid_q, r_valid_d;
  logic [MP*32-1:0]  r_data_q, r_data_d;

  logic [CNT_W-1:0]  n_gnt_q, n_gnt_d, n_conflict_q, n_conflict_d;
  logic [INC_W-1:0]  n_gnt_inc, n_conf_inc;
  logic [SUM_W-1:0]  n_gnt_sum, n_conf_sum;

  logic              unused_inputs;
  assign unused_inputs = ^{test_mode_i, tcdm_add_i};

  // Upper address bits beyond bank+row are dropped, so addresses simply wrap.
  always_comb begin
    for (int p = 0; p < MP; p++) begin
      port_row[p]  = tcdm_add_i[p*32 + 2 + BANK_SH +: ROW_W];
      port_bank[p] = (N_BANKS > 1) ? tcdm_add_i[p*32 + 2 +: BK_W] : '0;
    end
  end

  always_comb begin
    int idx;
    idx      = 0;
    win      = '0;
    bank_hit = '0;
    for (int k = 0; k < N_BANKS; k++) begin
      bank_port[k] = '0;
      rr_ptr_d[k]  = rr_ptr_q[k];
      for (int o = 0; o < MP; o++) begin
        idx = rr_port(rr_ptr_q[k], o);
        if (!bank_hit[k] && tcdm_req_i[idx] && !stall_i[idx] && port_bank[idx] == BK_W'(k)) begin
          bank_hit[k]  = 1'b1;
          bank_port[k] = PTR_W'(idx);
        end
      end
      if (bank_hit[k]) begin
        win[bank_port[k]] = 1'b1;
        rr_ptr_d[k]       = PTR_W'(rr_port(bank_port[k], 1));
      end
      if (clear_i) begin
        rr_ptr_d[k] = '0;
      end
    end
    gnt = (clear_i || !rst_ni) ? '0 : win;
  end

  // A bank winner still commits its write on a clear edge even though gnt is hidden from the master.
  always_comb begin
    for (int k = 0; k < N_BANKS; k++) begin
      bank_we[k]    = bank_hit[k] && !tcdm_wen_i[bank_port[k]] && rst_ni;
      bank_row[k]   = port_row[bank_port[k]];
      bank_wdata[k] = tcdm_data_i[int'(bank_port[k])*32 +: 32];
      bank_be[k]    = tcdm_be_i[int'(bank_port[k])*4 +: 4];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < N_BANKS; k++) begin
      for (int i = 0; i < 4; i++) begin
        if (bank_we[k] && bank_be[k][i]) begin
          mem_q[k][bank_row[k]][8*i +: 8] <= bank_wdata[k][8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    r_valid_d = gnt;
    r_data_d  = '0;
    for (int p = 0; p < MP; p++) begin
      if (gnt[p] && tcdm_wen_i[p]) begin
        r_data_d[p*32 +: 32] = mem_q[port_bank[p]][port_row[p]];
      end
    end
  end

  always_comb begin
    n_gnt_inc  = '0;
    n_conf_inc = '0;
    for (int p = 0; p < MP; p++) begin
      n_gnt_inc  = n_gnt_inc + INC_W'(gnt[p]);
      n_conf_inc = n_conf_inc + INC_W'(tcdm_req_i[p] & ~stall_i[p] & ~gnt[p]);
    end
    n_gnt_sum    = {1'b0, n_gnt_q} + SUM_W'(n_gnt_inc);
    n_conf_sum   = {1'b0, n_conflict_q} + SUM_W'(n_conf_inc);
    n_gnt_d      = n_gnt_sum[CNT_W]  ? '1 : n_gnt_sum[CNT_W-1:0];
    n_conflict_d = n_conf_sum[CNT_W] ? '1 : n_conf_sum[CNT_W-1:0];
    if (clear_i) begin
      n_gnt_d      = '0;
      n_conflict_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_q    <= '0;
      r_data_q     <= '0;
      n_gnt_q      <= '0;
      n_conflict_q <= '0;
      for (int k = 0; k < N_BANKS; k++) begin
        rr_ptr_q[k] <= '0;
      end
    end else begin
      r_valid_q    <= r_valid_d;
      r_data_q     <= r_data_d;
      n_gnt_q      <= n_gnt_d;
      n_conflict_q <= n_conflict_d;
      for (int k = 0; k < N_BANKS; k++) begin
        rr_ptr_q[k] <= rr_ptr_d[k];
      end
    end
  end

  // Clear drops the response of the previous cycle's grants as soon as it is seen.
  assign tcdm_gnt_o     = gnt;
  assign tcdm_r_valid_o = r_valid_q & ~{MP{clear_i}};
  assign tcdm_r_data_o  = clear_i ? '0 : r_data_q;
  assign n_gnt_o        = n_gnt_q;
  assign n_conflict_o   = n_conflict_q;

endmodule
